// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//   Brings up the board PLL from the 100 MHz input clock: drives a timed
//   PLL reset pulse, waits for LOCKED with a timeout, and only raises
//   clk_ready once LOCKED has held steady. A timed-out attempt is retried a
//   bounded number of times before the block parks in FAULT. Lock loss in RUN
//   restarts the sequence. Power-down and software restart requests are
//   serviced from any state.
//
// Ports
//   clk          in   100 MHz free-running clock (PLL CLKIN domain)
//   rst_n        in   asynchronous active-low reset
//   pll_locked   in   PLL LOCKED, asynchronous to clk
//   restart      in   single-cycle pulse: restart sequence, clear retries/fault
//   pwrdn_req    in   level: hold the PLL powered down while high
//   pll_rst      out  PLL RST
//   pll_pwrdwn   out  PLL PWRDWN
//   clk_ready    out  high only in RUN
//   fault        out  high in FAULT (retries exhausted)
//   retries      out  failed attempts in the current sequence (saturating)
//   lock_losses  out  lock losses seen in RUN (saturating, cleared by rst_n)
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 100000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRIES  = 3,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart,
    input  logic       pwrdn_req,
    output logic       pll_rst,
    output logic       pll_pwrdwn,
    output logic       clk_ready,
    output logic       fault,
    output logic [7:0] retries,
    output logic [7:0] lock_losses
);

    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_ALL = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
    localparam int CW      = $clog2(MAX_ALL + 1);

    // Terminal counts: the counter starts at 0 on state entry, so the last
    // cycle of an N-cycle phase is seen with the counter at N-1.
    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO     = CW'(0);
    localparam logic [7:0]    RETRY_LIMIT  = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4,
        ST_PWRDN     = 3'd5
    } state_e;

    // Saturating 8-bit increment used by both event counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'd255) begin
            sat_inc8 = v;
        end else begin
            sat_inc8 = v + 8'd1;
        end
    endfunction

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   locked_s;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_step_s;
    logic [7:0]  retries_q, retries_d;
    logic [7:0]  lock_losses_q, lock_losses_d;
    logic        pll_rst_q, pll_rst_d;
    logic        pll_pwrdwn_q, pll_pwrdwn_d;
    logic        clk_ready_q, clk_ready_d;
    logic        fault_q, fault_d;
    logic        seq_restart_s;

    // Shift pll_locked into the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Synchroniser flops for the asynchronous LOCKED input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    // Next-state, counter and counter-register logic; outputs are decoded from
    // the next state so each registered output lines up with the state it
    // describes (clk_ready falls on the very edge that leaves RUN).
    always_comb begin
        state_d       = state_q;
        cnt_step_s    = cnt_q;
        retries_d     = retries_q;
        lock_losses_d = lock_losses_q;
        seq_restart_s = 1'b0;

        if (pwrdn_req) begin
            state_d = ST_PWRDN;
        end else if (restart && (state_q != ST_PWRDN)) begin
            state_d       = ST_HOLD;
            retries_d     = 8'd0;
            seq_restart_s = 1'b1;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        cnt_step_s = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock is checked first so it wins over a same-cycle timeout.
                    if (locked_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retries_q == RETRY_LIMIT) begin
                            state_d = ST_FAULT;
                        end else begin
                            retries_d = sat_inc8(retries_q);
                            state_d   = ST_HOLD;
                        end
                    end else begin
                        cnt_step_s = cnt_q + CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_step_s = cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        lock_losses_d = sat_inc8(lock_losses_q);
                        retries_d     = 8'd0;
                        state_d       = ST_HOLD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                ST_PWRDN: begin
                    // Only reached here with pwrdn_req low.
                    retries_d = 8'd0;
                    state_d   = ST_HOLD;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end

        // Counter restarts from zero on every state change and on a restart.
        cnt_d = ((state_d != state_q) || seq_restart_s) ? CNT_ZERO : cnt_step_s;

        pll_rst_d    = (state_d == ST_HOLD) || (state_d == ST_FAULT) || (state_d == ST_PWRDN);
        pll_pwrdwn_d = (state_d == ST_PWRDN);
        clk_ready_d  = (state_d == ST_RUN);
        fault_d      = (state_d == ST_FAULT);
    end

    // State, counter, event counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HOLD;
            cnt_q         <= CNT_ZERO;
            retries_q     <= 8'd0;
            lock_losses_q <= 8'd0;
            pll_rst_q     <= 1'b1;
            pll_pwrdwn_q  <= 1'b0;
            clk_ready_q   <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retries_q     <= retries_d;
            lock_losses_q <= lock_losses_d;
            pll_rst_q     <= pll_rst_d;
            pll_pwrdwn_q  <= pll_pwrdwn_d;
            clk_ready_q   <= clk_ready_d;
            fault_q       <= fault_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign pll_pwrdwn  = pll_pwrdwn_q;
    assign clk_ready   = clk_ready_q;
    assign fault       = fault_q;
    assign retries     = retries_q;
    assign lock_losses = lock_losses_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//   Self-checking bench for pll_lock_sequencer with RST_CYCLES=4,
//   LOCK_TIMEOUT=50, LOCK_STABLE=8, MAX_RETRIES=2, SYNC_STAGES=2.
//   Expected output snapshots are pushed to a queue when stimulus is driven
//   and popped/compared once the DUT has had the cycles to respond; phase
//   lengths (reset pulse, timeout wait, lock-to-ready latency) are measured
//   by bounded loops and compared against constants.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       restart;
    logic       pwrdn_req;
    logic       pll_rst;
    logic       pll_pwrdwn;
    logic       clk_ready;
    logic       fault;
    logic [7:0] retries;
    logic [7:0] lock_losses;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       pwr;
        logic       rdy;
        logic       flt;
        logic [7:0] ret;
        logic [7:0] ll;
    } exp_t;

    typedef struct {
        string      name;
        logic       locked;
        logic       rst_req;
        logic       pwr_req;
        int         ticks;
        logic       e_rst;
        logic       e_pwr;
        logic       e_rdy;
        logic       e_flt;
        logic [7:0] e_ret;
        logic [7:0] e_ll;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];

    localparam int SEL_RST = 0;
    localparam int SEL_RDY = 1;

    pll_lock_sequencer #(
        .RST_CYCLES  (4),
        .LOCK_TIMEOUT(50),
        .LOCK_STABLE (8),
        .MAX_RETRIES (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pwrdn_req  (pwrdn_req),
        .pll_rst    (pll_rst),
        .pll_pwrdwn (pll_pwrdwn),
        .clk_ready  (clk_ready),
        .fault      (fault),
        .retries    (retries),
        .lock_losses(lock_losses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string name, input logic rst, input logic pwr, input logic rdy,
                            input logic flt, input logic [7:0] ret, input logic [7:0] ll);
        exp_t e;
        e.name = name; e.rst = rst; e.pwr = pwr; e.rdy = rdy;
        e.flt = flt; e.ret = ret; e.ll = ll;
        sb_q.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_empty: no expected entry queued");
        end else begin
            e = sb_q.pop_front();
            if ({pll_rst, pll_pwrdwn, clk_ready, fault, retries, lock_losses} !==
                {e.rst, e.pwr, e.rdy, e.flt, e.ret, e.ll}) begin
                tests_failed++;
                $display("FAIL %s: got rst=%b pwrdwn=%b ready=%b fault=%b retries=%0d losses=%0d, expected rst=%b pwrdwn=%b ready=%b fault=%b retries=%0d losses=%0d",
                         e.name, pll_rst, pll_pwrdwn, clk_ready, fault, retries, lock_losses,
                         e.rst, e.pwr, e.rdy, e.flt, e.ret, e.ll);
            end
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic sig_val(input int sel);
        if (sel == SEL_RST) begin
            return pll_rst;
        end else begin
            return clk_ready;
        end
    endfunction

    // Count clock ticks until the selected output reaches val (bounded).
    task automatic wait_for(input int sel, input logic val, input int limit, output int n);
        n = 0;
        while ((sig_val(sel) !== val) && (n < limit)) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int m;
        int done;

        // Power-down / restart priority table, applied from RUN with
        // lock_losses=2 and locked held high.
        vecs[0] = '{"pwrdn_beats_restart",  1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd2};
        vecs[1] = '{"restart_in_pwrdn",     1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd2};
        vecs[2] = '{"pwrdn_held",           1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd2};
        vecs[3] = '{"pwrdn_exit_to_hold",   1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd2};
        vecs[4] = '{"hold_after_pwrdn",     1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd2};
        vecs[5] = '{"run_after_pwrdn",      1'b1, 1'b0, 1'b0, 9, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd2};

        rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0; pwrdn_req = 1'b0;
        repeat (3) tick();
        push_exp("reset_state", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        check_sb();

        // Normal bring-up: 4-cycle PLL reset, lock raised 10 cycles after release.
        rst_n = 1'b1;
        wait_for(SEL_RST, 1'b0, 20, n);
        check_int("first_rst_pulse_len", n, 4);
        repeat (6) tick();
        pll_locked = 1'b1;
        wait_for(SEL_RDY, 1'b1, 40, n);
        check_int("lock_to_ready_latency", n, 11);
        push_exp("run_entry", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        check_sb();

        // One-cycle lock drop in RUN.
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_for(SEL_RDY, 1'b0, 20, m);
        check_int("loss_to_ready_fall", m + 1, 3);
        push_exp("after_lock_loss", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1);
        check_sb();
        wait_for(SEL_RST, 1'b0, 20, n);
        check_int("loss_rst_pulse_len", n, 4);
        wait_for(SEL_RDY, 1'b1, 40, n);
        check_int("relock_ready_latency", n, 9);

        // Drop lock and hold it low to land in WAIT_LOCK, then a glitchy lock.
        pll_locked = 1'b0;
        wait_for(SEL_RDY, 1'b0, 20, n);
        check_int("second_loss_fall", n, 3);
        wait_for(SEL_RST, 1'b0, 20, n);
        check_int("second_loss_rst_len", n, 4);
        pll_locked = 1'b1;
        n = 0;
        done = 0;
        while ((done == 0) && (n < 40)) begin
            tick();
            n++;
            if (n == 5) pll_locked = 1'b0;
            if (n == 6) pll_locked = 1'b1;
            if (n == 12) check_int("glitch_no_early_run", int'(clk_ready), 0);
            if (clk_ready) done = 1;
        end
        check_int("glitch_ready_latency", n, 17);

        // Table-driven power-down / restart priority.
        for (int i = 0; i < 6; i++) begin
            pll_locked = vecs[i].locked;
            restart    = vecs[i].rst_req;
            pwrdn_req  = vecs[i].pwr_req;
            push_exp(vecs[i].name, vecs[i].e_rst, vecs[i].e_pwr, vecs[i].e_rdy,
                     vecs[i].e_flt, vecs[i].e_ret, vecs[i].e_ll);
            repeat (vecs[i].ticks) tick();
            check_sb();
        end
        restart   = 1'b0;
        pwrdn_req = 1'b0;

        // Lock never arrives: restart from RUN, then exhaust retries.
        pll_locked = 1'b0;
        restart    = 1'b1;
        tick();
        restart = 1'b0;
        push_exp("restart_from_run", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd2);
        check_sb();
        for (int k = 0; k < 3; k++) begin
            wait_for(SEL_RST, 1'b0, 20, n);
            check_int("timeout_hold_len", n, 4);
            wait_for(SEL_RST, 1'b1, 100, n);
            check_int("timeout_wait_len", n, 50);
            push_exp("after_timeout", 1'b1, 1'b0, 1'b0, (k == 2),
                     (k < 2) ? 8'(k + 1) : 8'd2, 8'd2);
            check_sb();
        end
        repeat (20) tick();
        push_exp("fault_persists", 1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 8'd2);
        check_sb();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        push_exp("restart_clears_fault", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd2);
        check_sb();
        wait_for(SEL_RST, 1'b0, 20, n);
        check_int("restart_hold_len", n, 4);

        // Let one more timeout bump retries, then assert rst_n mid-WAIT_LOCK.
        repeat (56) tick();
        push_exp("pre_async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd2);
        check_sb();
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("async_reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        check_sb();
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
